alu_pipe: RTL
=============

# alu_pipe

Two-stage pipelined successor to the combinational ALU, parametrised in `REG_WIDTH`. It accepts one operation per cycle over a valid/ready handshake. It computes arithmetic, logic and shift results, holds an architectural NZCV flag register that carry-chained ops (ADC/SBC) consume, and presents results on a stallable output stage. It sits between register-read and writeback in the execute path.

## Interface
- `REG_WIDTH`, default 16: operand/result width; must be ≥4 and a power of two.
- `SHIFT_WIDTH`, default `$clog2(REG_WIDTH)`: shift-amount width; derived, not overridden.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  drops both pipeline stages; flags kept.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `op`  in  4  operation code (see Operation).
- `setflags`  in  1  update NZCV with this op's result.
- `ra`, `rb`  in  REG_WIDTH each  operands; `rb[SHIFT_WIDTH-1:0]` is the shift amount.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out`  out  REG_WIDTH  result.
- `out_err`  out  1  result came from a reserved op.
- `flagn`, `flagz`, `flagc`, `flagv`  out  1 each  architectural flags.

## Operation
- S1 is the input register: op, setflags, ra, rb, valid.
- Compute happens on the S1→S2 transfer. S2 holds out, err, valid. The flag register updates on the same edge.
- Compute and flag commit occur in program order at one point, so ADC/SBC always read fully committed C. No forwarding or hazard logic exists.
- Op codes:
  - 0 ADD: ra+rb
  - 1 ADC: ra+rb+C
  - 2 SUB: ra-rb
  - 3 SBC: ra-rb-!C
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 BIC: ra&~rb
  - 8 LSL
  - 9 LSR
  - 10 ASR
  - 11 ROR
  - 12 MOV: rb
  - 13 MVN: ~rb
  - 14–15 reserved
- Arithmetic uses a REG_WIDTH+1-bit sum.
  - Add: C = carry-out.
  - Sub: C = NOT borrow, computed as ra + ~rb + cin with cin=1 for SUB and cin=C for SBC. SUB with ra ≥ rb unsigned gives C=1.
  - V = signed overflow: operand sign bits equal (after rb inversion for sub) and result sign differs.
- Logic ops and MOV/MVN: C and V unchanged.
- Shifts use amount s = `rb[SHIFT_WIDTH-1:0]`. Upper rb bits are ignored.
  - s=0: result = ra; C unchanged.
  - s>0: C = last bit shifted out. LSL: `ra[REG_WIDTH-s]`. LSR/ASR/ROR: `ra[s-1]`.
  - V unchanged for all shifts.
- N = `out[REG_WIDTH-1]`; Z = (out==0). Both apply to all non-reserved ops.
- Flags change only when the op has setflags=1 and is non-reserved.
- Reserved op: out=0, out_err=1, flags unchanged regardless of setflags.

## Timing
- Reset (async assert, sync-safe deassert):
  - S1/S2 valid=0, out=0, out_err=0.
  - All flags 0.
  - `in_ready`=1 on first cycle after reset.
- S2 advance: `s2_adv = !out_valid || out_ready`.
- S1 advance: S1→S2 transfer when `s1_valid && s2_adv`.
- `in_ready = !flush && (!s1_valid || s2_adv)` (combinational).
- Latency: accepted at edge N → `out_valid` high after edge N+1. This is 2 cycles.
- Throughput: 1 op/cycle when `out_ready` is held high.
- Stall: `out_valid && !out_ready` holds `out`, `out_err` and flags stable. S1 holds its op. `in_ready` drops once S1 is full.
- Bubble: S1 empty while S2 drains gives `out_valid`=0 next cycle; out keeps its last value.
- Flush: next edge clears both valids, and no flag update occurs from S1's pending op. A handshake in the flush cycle is not accepted (`in_ready`=0). Flags keep all previously committed updates.
- Simultaneous S2 consume and S1→S2 transfer in one edge: new result replaces old; no bubble.
- Reset mid-stall: all state cleared immediately; the pending op is lost.
- Output registers only; no combinational path from `ra`/`rb`/`op` to `out` or flags.

## Test plan
- REG_WIDTH=16, ADD setflags 0x7FFF+0x0001 → out 0x8000 two cycles after accept; N=1, Z=0, C=0, V=1.
- SUB setflags 0x0005-0x0005 → out 0x0000, Z=1, C=1, V=0. Then back-to-back SBC 0x0000-0x0001 → out 0xFFFF, C=0, N=1.
- Back-to-back ADD 0xFFFF+0x0001 (setflags) then ADC 0x0000+0x0000 → outs 0x0000 and 0x0001, in consecutive cycles at 1 op/cycle.
- Shifts on ra=0x8001:
  - LSL by 1 → 0x0002, C=1.
  - ASR by 4 → 0xF800, C=0.
  - ROR by 1 → 0xC000, C=1.
  - LSL by 0 → 0x8001, C unchanged.
  - rb=0x0011 → shift by 1.
- Stall: `out_ready`=0 for 5 cycles with 3 ops offered → 2 accepted, `in_ready`=0 thereafter; out and flags stable. Release → ops emerge in order, no loss or duplication.
- Reserved op 14 with setflags=1 → out 0, out_err=1, flags unchanged. Flush with S1/S2 full → both drop, flags unchanged. `rst_n` low mid-stream → all outputs and flags 0 immediately.

Source files
------------

// File: rtl/alu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pipe: two-stage ALU, valid/ready in and out, NZCV register.            |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module alu_pipe #(
    parameter int REG_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic                 setflags,
    input  logic [REG_WIDTH-1:0] ra,
    input  logic [REG_WIDTH-1:0] rb,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] out,
    output logic                 out_err,
    output logic                 flagn,
    output logic                 flagz,
    output logic                 flagc,
    output logic                 flagv
);

    localparam int SHIFT_WIDTH = $clog2(REG_WIDTH);
    localparam int MSB         = REG_WIDTH - 1;

    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_adc = 4'd1;
    localparam logic [3:0] c_op_sub = 4'd2;
    localparam logic [3:0] c_op_sbc = 4'd3;
    localparam logic [3:0] c_op_and = 4'd4;
    localparam logic [3:0] c_op_or  = 4'd5;
    localparam logic [3:0] c_op_xor = 4'd6;
    localparam logic [3:0] c_op_bic = 4'd7;
    localparam logic [3:0] c_op_lsl = 4'd8;
    localparam logic [3:0] c_op_lsr = 4'd9;
    localparam logic [3:0] c_op_asr = 4'd10;
    localparam logic [3:0] c_op_ror = 4'd11;
    localparam logic [3:0] c_op_mov = 4'd12;
    localparam logic [3:0] c_op_mvn = 4'd13;

    localparam logic [SHIFT_WIDTH:0] c_width = (SHIFT_WIDTH + 1)'(REG_WIDTH);

    // Stage 1: input register
    logic                 r_s1_valid;
    logic [3:0]           r_s1_op;
    logic                 r_s1_setflags;
    logic [REG_WIDTH-1:0] r_s1_ra;
    logic [REG_WIDTH-1:0] r_s1_rb;

    // Stage 2: output register
    logic                 r_s2_valid;
    logic [REG_WIDTH-1:0] r_out;
    logic                 r_err;

    logic r_flag_n;
    logic r_flag_z;
    logic r_flag_c;
    logic r_flag_v;

    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;

    logic                   w_is_sub;
    logic [REG_WIDTH-1:0]   w_b_op;
    logic                   w_cin;
    logic [REG_WIDTH:0]     w_sum;
    logic                   w_arith_v;
    logic [SHIFT_WIDTH-1:0] w_sh;
    logic                   w_sh_zero;
    logic [REG_WIDTH:0]     w_lsl;
    logic [REG_WIDTH:0]     w_lsr;
    logic signed [REG_WIDTH:0] w_asr;
    logic [SHIFT_WIDTH:0]   w_ror_back;
    logic [REG_WIDTH-1:0]   w_ror;

    logic [REG_WIDTH-1:0] w_res;
    logic                 w_err;
    logic                 w_c;
    logic                 w_v;
    logic                 w_flag_we;

    // ---------------- handshake ----------------
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = r_s1_valid && w_s2_adv;
    assign in_ready = !flush && (!r_s1_valid || w_s2_adv);
    assign w_accept = in_valid && in_ready;

    // ---------------- datapath ----------------
    assign w_is_sub = (r_s1_op == c_op_sub) || (r_s1_op == c_op_sbc);
    assign w_b_op   = w_is_sub ? ~r_s1_rb : r_s1_rb;

    always_comb begin
        w_cin = 1'b0;
        case (r_s1_op)
            c_op_adc: w_cin = r_flag_c;
            c_op_sub: w_cin = 1'b1;
            c_op_sbc: w_cin = r_flag_c;
            default:  w_cin = 1'b0;
        endcase
    end

    assign w_sum     = {1'b0, r_s1_ra} + {1'b0, w_b_op} + {{REG_WIDTH{1'b0}}, w_cin};
    assign w_arith_v = (r_s1_ra[MSB] == w_b_op[MSB]) && (w_sum[MSB] != r_s1_ra[MSB]);

    // Each shift carries one guard bit so the last bit shifted out falls into it.
    assign w_sh       = r_s1_rb[SHIFT_WIDTH-1:0];
    assign w_sh_zero  = (w_sh == '0);
    assign w_lsl      = {1'b0, r_s1_ra} << w_sh;
    assign w_lsr      = {r_s1_ra, 1'b0} >> w_sh;
    assign w_asr      = $signed({r_s1_ra, 1'b0}) >>> w_sh;
    assign w_ror_back = c_width - {1'b0, w_sh};
    assign w_ror      = (r_s1_ra >> w_sh) | (r_s1_ra << w_ror_back);

    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        w_c   = r_flag_c;
        w_v   = r_flag_v;
        case (r_s1_op)
            c_op_add, c_op_adc, c_op_sub, c_op_sbc: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[REG_WIDTH];
                w_v   = w_arith_v;
            end
            c_op_and: w_res = r_s1_ra & r_s1_rb;
            c_op_or:  w_res = r_s1_ra | r_s1_rb;
            c_op_xor: w_res = r_s1_ra ^ r_s1_rb;
            c_op_bic: w_res = r_s1_ra & ~r_s1_rb;
            c_op_lsl: begin
                w_res = w_lsl[MSB:0];
                w_c   = w_sh_zero ? r_flag_c : w_lsl[REG_WIDTH];
            end
            c_op_lsr: begin
                w_res = w_lsr[REG_WIDTH:1];
                w_c   = w_sh_zero ? r_flag_c : w_lsr[0];
            end
            c_op_asr: begin
                w_res = w_asr[REG_WIDTH:1];
                w_c   = w_sh_zero ? r_flag_c : w_asr[0];
            end
            c_op_ror: begin
                w_res = w_ror;
                w_c   = w_sh_zero ? r_flag_c : w_ror[MSB];
            end
            c_op_mov: w_res = r_s1_rb;
            c_op_mvn: w_res = ~r_s1_rb;
            default: begin
                w_res = '0;
                w_err = 1'b1;
            end
        endcase
    end

    assign w_flag_we = !flush && w_s1_adv && r_s1_setflags && !w_err;

    // ---------------- stage 1 ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_op       <= '0;
            r_s1_setflags <= 1'b0;
            r_s1_ra       <= '0;
            r_s1_rb       <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid    <= 1'b1;
            r_s1_op       <= op;
            r_s1_setflags <= setflags;
            r_s1_ra       <= ra;
            r_s1_rb       <= rb;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // ---------------- stage 2 ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out      <= '0;
            r_err      <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_out      <= w_res;
            r_err      <= w_err;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Flags commit on the same edge as the result, so ADC/SBC never see a stale C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_v <= 1'b0;
        end else if (w_flag_we) begin
            r_flag_n <= w_res[MSB];
            r_flag_z <= (w_res == '0);
            r_flag_c <= w_c;
            r_flag_v <= w_v;
        end
    end

    assign out_valid = r_s2_valid;
    assign out       = r_out;
    assign out_err   = r_err;
    assign flagn     = r_flag_n;
    assign flagz     = r_flag_z;
    assign flagc     = r_flag_c;
    assign flagv     = r_flag_v;

endmodule
`default_nettype wire
